// File: rtl/npu_pkg.sv
// Shared types and width helpers for the systolic matmul engine.
package npu_pkg;

    // Job sequencing states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_OUTPUT,
        S_FIN
    } state_t;

    // Accumulator/result width: full product plus headroom for KMAX additions.
    function automatic int unsigned calc_aw(input int unsigned dw, input int unsigned kmax);
        return 2 * dw + $clog2(kmax);
    endfunction

    // Width able to hold 0..KMAX.
    function automatic int unsigned calc_kw(input int unsigned kmax);
        return $clog2(kmax + 1);
    endfunction

    // Width of a row index.
    function automatic int unsigned calc_rw(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element: forwards A right and B down, accumulates A*B when both tags are set.
module mac_pe #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 22,
    parameter bit          SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic [DW-1:0] i_a,
    input  logic          i_a_v,
    input  logic [DW-1:0] i_b,
    input  logic          i_b_v,
    output logic [DW-1:0] o_a,
    output logic          o_a_v,
    output logic [DW-1:0] o_b,
    output logic          o_b_v,
    output logic [AW-1:0] o_acc
);

    localparam int unsigned PW = 2 * DW + 2;

    logic signed [DW:0]   w_a_ext;
    logic signed [DW:0]   w_b_ext;
    logic signed [PW-1:0] w_prod;
    logic        [AW-1:0] w_prod_ext;
    logic        [AW-1:0] r_acc;

    // One extra bit lets a single signed multiply cover both operand modes.
    assign w_a_ext    = SIGNED ? {i_a[DW-1], i_a} : {1'b0, i_a};
    assign w_b_ext    = SIGNED ? {i_b[DW-1], i_b} : {1'b0, i_b};
    assign w_prod     = PW'(w_a_ext) * PW'(w_b_ext);
    assign w_prod_ext = AW'(w_prod);
    assign o_acc      = r_acc;

    // Operand/tag pass-through registers and the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a   <= '0;
            o_a_v <= 1'b0;
            o_b   <= '0;
            o_b_v <= 1'b0;
            r_acc <= '0;
        end else begin
            o_a   <= i_a;
            o_a_v <= i_a_v;
            o_b   <= i_b;
            o_b_v <= i_b_v;
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_a_v && i_b_v) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

endmodule

// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic array computing C = A * B over k_len beats.
module systolic_matmul_engine
    import npu_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DW     = 8,
    parameter int unsigned KMAX   = 64,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [calc_kw(KMAX)-1:0]              k_len,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [N-1:0][DW-1:0]                  a_vec,
    input  logic [N-1:0][DW-1:0]                  b_vec,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [calc_rw(N)-1:0]                 res_row,
    output logic [N-1:0][calc_aw(DW, KMAX)-1:0]   res_data
);

    localparam int unsigned AW  = calc_aw(DW, KMAX);
    localparam int unsigned KW  = calc_kw(KMAX);
    localparam int unsigned RW  = calc_rw(N);
    localparam int unsigned DCW = $clog2(2 * N);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          w_clr;
    logic                          w_xfer;
    logic [RW-1:0]                 w_row_nxt;
    logic [KW-1:0]                 r_klen;
    logic [KW-1:0]                 r_kcnt;
    logic [DCW-1:0]                r_dcnt;
    logic [RW-1:0]                 r_row;
    logic                          r_a_ready;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_res_valid;
    logic [N-1:0][AW-1:0]          r_res_data;
    logic [N-1:0][N-1:0][AW-1:0]   w_acc;

    logic [DW-1:0] w_a_d [N][N+1];
    logic          w_a_t [N][N+1];
    logic [DW-1:0] w_b_d [N+1][N];
    logic          w_b_t [N+1][N];
    logic [N-1:0]  w_unused_edge;

    assign w_xfer    = (r_state == S_FEED) && a_valid;
    assign a_ready   = r_a_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign res_valid = r_res_valid;
    assign res_row   = r_row;
    assign res_data  = r_res_data;

    // Next-state, accumulator clear and next presented row.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_row_nxt   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        w_state_nxt = S_FEED;
                        w_clr       = 1'b1;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FEED: begin
                if (w_xfer && (r_kcnt == r_klen - KW'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DCW'(2 * N - 2)) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (!res_ready) begin
                    w_row_nxt = r_row;
                end else if (r_row == RW'(N - 1)) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_row_nxt = r_row + RW'(1);
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_klen      <= '0;
            r_kcnt      <= '0;
            r_dcnt      <= '0;
            r_row       <= '0;
            r_a_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_a_ready   <= (w_state_nxt == S_FEED);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FIN);
            r_res_valid <= (w_state_nxt == S_OUTPUT);
            r_res_data  <= (w_state_nxt == S_OUTPUT) ? w_acc[w_row_nxt] : '0;
            r_dcnt      <= (r_state == S_DRAIN) ? r_dcnt + DCW'(1) : '0;
            if (w_clr) begin
                r_klen <= k_len;
                r_kcnt <= '0;
            end else if (w_xfer) begin
                r_kcnt <= r_kcnt + KW'(1);
            end
        end
    end

    // Input skew: lane g of A and of B is delayed g cycles; both share one tag chain.
    for (genvar g = 0; g < N; g++) begin : g_skew
        if (g == 0) begin : g_direct
            assign w_a_d[0][0] = a_vec[0];
            assign w_a_t[0][0] = w_xfer;
            assign w_b_d[0][0] = b_vec[0];
            assign w_b_t[0][0] = w_xfer;
        end else begin : g_delay
            logic [DW-1:0] r_a_sk [g];
            logic [DW-1:0] r_b_sk [g];
            logic          r_t_sk [g];

            // Shift chain of depth g.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < g; d++) begin
                        r_a_sk[d] <= '0;
                        r_b_sk[d] <= '0;
                        r_t_sk[d] <= 1'b0;
                    end
                end else begin
                    r_a_sk[0] <= a_vec[g];
                    r_b_sk[0] <= b_vec[g];
                    r_t_sk[0] <= w_xfer;
                    for (int d = 1; d < g; d++) begin
                        r_a_sk[d] <= r_a_sk[d-1];
                        r_b_sk[d] <= r_b_sk[d-1];
                        r_t_sk[d] <= r_t_sk[d-1];
                    end
                end
            end

            assign w_a_d[g][0] = r_a_sk[g-1];
            assign w_a_t[g][0] = r_t_sk[g-1];
            assign w_b_d[0][g] = r_b_sk[g-1];
            assign w_b_t[0][g] = r_t_sk[g-1];
        end

        // Operands leaving the right and bottom edges have no consumer.
        assign w_unused_edge[g] = ^{w_a_t[g][N], w_a_d[g][N], w_b_t[N][g], w_b_d[N][g]};
    end

    // PE grid: A flows along rows, B down columns.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mac_pe #(
                .DW     (DW),
                .AW     (AW),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .i_clr (w_clr),
                .i_a   (w_a_d[i][j]),
                .i_a_v (w_a_t[i][j]),
                .i_b   (w_b_d[i][j]),
                .i_b_v (w_b_t[i][j]),
                .o_a   (w_a_d[i][j+1]),
                .o_a_v (w_a_t[i][j+1]),
                .o_b   (w_b_d[i+1][j]),
                .o_b_v (w_b_t[i+1][j]),
                .o_acc (w_acc[i][j])
            );
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed bench: an unsigned and a signed 2x2 engine share stimulus; results checked per instance.
module tb_systolic_matmul_engine;

    localparam int unsigned N    = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned KMAX = 64;
    localparam int unsigned AW   = 22;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [6:0]              k_len;
    logic                    a_valid;
    logic [N-1:0][DW-1:0]    a_vec;
    logic [N-1:0][DW-1:0]    b_vec;
    logic                    res_ready;

    logic                    a_ready_u, busy_u, done_u, res_valid_u;
    logic                    res_row_u;
    logic [N-1:0][AW-1:0]    res_data_u;
    logic                    a_ready_s, busy_s, done_s, res_valid_s;
    logic                    res_row_s;
    logic [N-1:0][AW-1:0]    res_data_s;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 clk = ~clk;

    systolic_matmul_engine #(.N(N), .DW(DW), .KMAX(KMAX), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_valid(a_valid), .a_ready(a_ready_u), .a_vec(a_vec), .b_vec(b_vec),
        .busy(busy_u), .done(done_u), .res_valid(res_valid_u), .res_ready(res_ready),
        .res_row(res_row_u), .res_data(res_data_u)
    );

    systolic_matmul_engine #(.N(N), .DW(DW), .KMAX(KMAX), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_valid(a_valid), .a_ready(a_ready_s), .a_vec(a_vec), .b_vec(b_vec),
        .busy(busy_s), .done(done_s), .res_valid(res_valid_s), .res_ready(res_ready),
        .res_row(res_row_s), .res_data(res_data_s)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_a_ready"},   64'(a_ready_u),     64'(0));
        check_eq({tag, "_busy"},      64'(busy_u),        64'(0));
        check_eq({tag, "_done"},      64'(done_u),        64'(0));
        check_eq({tag, "_res_valid"}, 64'(res_valid_u),   64'(0));
        check_eq({tag, "_res_row"},   64'(res_row_u),     64'(0));
        check_eq({tag, "_res_data"},  64'(res_data_u),    64'(0));
        check_eq({tag, "_s_ctrl"},    64'({a_ready_s, busy_s, done_s, res_row_s}), 64'(0));
        check_eq({tag, "_s_data"},    64'(res_data_s),    64'(0));
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = 7'(k);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("start_busy",    64'(busy_u),    64'(1));
        check_eq("start_a_ready", 64'(a_ready_u), 64'(1));
    endtask

    task automatic beat(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0, input logic [7:0] b1);
        a_vec[0] = a0;
        a_vec[1] = a1;
        b_vec[0] = b0;
        b_vec[1] = b1;
        a_valid  = 1'b1;
        @(posedge clk); #1;
        a_valid  = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid_u && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_row(input int r, input logic [AW-1:0] eu0, input logic [AW-1:0] eu1,
                            input logic [AW-1:0] es0, input logic [AW-1:0] es1);
        check_eq("res_valid_u", 64'(res_valid_u),   64'(1));
        check_eq("res_valid_s", 64'(res_valid_s),   64'(1));
        check_eq("res_row",     64'(res_row_u),     64'(r));
        check_eq("data_u0",     64'(res_data_u[0]), 64'(eu0));
        check_eq("data_u1",     64'(res_data_u[1]), 64'(eu1));
        check_eq("data_s0",     64'(res_data_s[0]), 64'(es0));
        check_eq("data_s1",     64'(res_data_s[1]), 64'(es1));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic finish_job();
        check_eq("fin_done",      64'(done_u),      64'(1));
        check_eq("fin_res_valid", 64'(res_valid_u), 64'(0));
        @(posedge clk); #1;
        check_eq("idle_done", 64'(done_u), 64'(0));
        check_eq("idle_busy", 64'(busy_u), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        a_valid   = 1'b0;
        a_vec     = '0;
        b_vec     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // A = I, B = [[1,2],[3,4]], back-to-back beats
        start_job(2);
        beat(8'd1, 8'd0, 8'd1, 8'd2);
        beat(8'd0, 8'd1, 8'd3, 8'd4);
        check_eq("drain_a_ready", 64'(a_ready_u), 64'(0));
        check_eq("drain_busy",    64'(busy_u),    64'(1));
        wait_res(cyc);
        check_eq("latency", 64'(cyc), 64'(3));
        read_row(0, 22'd1, 22'd2, 22'd1, 22'd2);
        read_row(1, 22'd3, 22'd4, 22'd3, 22'd4);
        finish_job();

        // Same job with 3 bubble cycles, then a 5-cycle consumer stall
        start_job(2);
        beat(8'd1, 8'd0, 8'd1, 8'd2);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("bubble_a_ready", 64'(a_ready_u), 64'(1));
        end
        beat(8'd0, 8'd1, 8'd3, 8'd4);
        check_eq("bubble_a_ready_end", 64'(a_ready_u), 64'(0));
        wait_res(cyc);
        check_eq("bubble_latency", 64'(cyc), 64'(3));
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("stall_valid", 64'(res_valid_u),   64'(1));
            check_eq("stall_row",   64'(res_row_u),     64'(0));
            check_eq("stall_data",  64'(res_data_u),    64'({22'd2, 22'd1}));
        end
        read_row(0, 22'd1, 22'd2, 22'd1, 22'd2);
        check_eq("no_early_done", 64'(done_u), 64'(0));
        read_row(1, 22'd3, 22'd4, 22'd3, 22'd4);
        finish_job();

        // k_len = 0, and a start coinciding with done is ignored
        start = 1'b1;
        k_len = 7'd0;
        @(posedge clk); #1;
        check_eq("k0_done",      64'(done_u),      64'(1));
        check_eq("k0_res_valid", 64'(res_valid_u), 64'(0));
        k_len = 7'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("k0_done_clear", 64'(done_u),      64'(0));
        check_eq("fin_start_ign", 64'(busy_u),      64'(0));
        check_eq("k0_a_ready",    64'(a_ready_u),   64'(0));
        check_eq("k0_res_valid2", 64'(res_valid_u), 64'(0));

        // k_len = 1, a = (0xFF, 2), b = (3, 0xFF): unsigned vs signed products
        start_job(1);
        beat(8'hFF, 8'h02, 8'h03, 8'hFF);
        wait_res(cyc);
        read_row(0, 22'd765, 22'd65025, 22'h3FFFFD, 22'd1);
        read_row(1, 22'd6,   22'd510,   22'd6,      22'h3FFFFE);
        finish_job();

        // Full depth with all operands 0x80 (-128 signed, 128 unsigned)
        start_job(64);
        repeat (64) beat(8'h80, 8'h80, 8'h80, 8'h80);
        wait_res(cyc);
        read_row(0, 22'h100000, 22'h100000, 22'h100000, 22'h100000);
        read_row(1, 22'h100000, 22'h100000, 22'h100000, 22'h100000);
        finish_job();

        // Reset after 1 of 4 beats, then a fresh 2-beat job
        start_job(4);
        beat(8'd9, 8'd9, 8'd9, 8'd9);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_no_done", 64'(done_u), 64'(0));
        start_job(2);
        beat(8'd1, 8'd3, 8'd5, 8'd6);
        beat(8'd2, 8'd4, 8'd7, 8'd8);
        wait_res(cyc);
        check_eq("post_rst_latency", 64'(cyc), 64'(3));
        read_row(0, 22'd19, 22'd22, 22'd19, 22'd22);
        read_row(1, 22'd43, 22'd50, 22'd43, 22'd50);
        finish_job();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_engine.md
SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

Interface
REQ-001 Parameter N, default 4: array dimension (N x N PEs), N >= 2.
REQ-002 Parameter DW, default 8: operand width in bits.
REQ-003 Parameter KMAX, default 64: maximum reduction depth per job.
REQ-004 Parameter SIGNED, default 0: 1 means two's-complement operands, 0 means unsigned.
REQ-005 Derived constant AW = 2*DW + clog2(KMAX): accumulator and result width.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  job request, sampled in IDLE only.
REQ-009 k_len  in  clog2(KMAX+1)  reduction depth, captured on an accepted start.
REQ-010 a_valid  in  1  operand beat valid.
REQ-011 a_ready  out  1  engine accepts an operand beat.
REQ-012 a_vec  in  N x DW  A column k, with element i feeding array row i.
REQ-013 b_vec  in  N x DW  B row k, with element j feeding array column j.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at job completion.
REQ-016 res_valid  out  1  result row available.
REQ-017 res_ready  in  1  consumer accepts the result row.
REQ-018 res_row  out  clog2(N)  index of the presented result row.
REQ-019 res_data  out  N x AW  C[res_row][0..N-1].

Function
REQ-020 The state machine SHALL have states IDLE, FEED, DRAIN, OUTPUT and FIN.
REQ-021 In IDLE, start=1 with k_len>0 SHALL capture k_len, clear all accumulators and move to FEED; start=1 with k_len=0 SHALL move to FIN with no result rows.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 In FEED, a_ready SHALL be 1; a beat transfers on a_valid&a_ready; a_ready SHALL be 0 in all other states.
REQ-024 After the k_len-th transfer the engine SHALL move to DRAIN, and SHALL accept no further beats.
REQ-025 Input skew: a_vec[i] delayed i cycles and b_vec[j] delayed j cycles; operands then pass one PE per cycle (A rightward, B downward), so beat t reaches PE(i,j) at t+i+j.
REQ-026 Every operand SHALL carry a valid tag; a PE SHALL accumulate only when both tags are set, so cycles with a_valid=0 insert bubbles with no effect on the result.
REQ-027 Each PE SHALL compute acc += A*B, extended to AW bits (sign-extended if SIGNED=1, else zero-extended); with AW as defined, overflow is impossible for k_len <= KMAX.
REQ-028 DRAIN SHALL last exactly 2N-1 cycles, counted by a counter, then move to OUTPUT.
REQ-029 OUTPUT SHALL present rows 0..N-1 in order; res_row and res_data SHALL hold stable while res_valid=1 and res_ready=0.
REQ-030 On the N-th res_valid&res_ready handshake the engine SHALL move to FIN.
REQ-031 FIN SHALL assert done for exactly one cycle and then return to IDLE; done and start may coincide without the new start being accepted.
REQ-032 Accumulators SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and zero all accumulators, skew registers, valid tags and counters.
REQ-034 Reset values SHALL be a_ready=0, busy=0, done=0, res_valid=0, res_row=0, res_data=0.
REQ-035 A reset asserted mid-job (FEED, DRAIN or OUTPUT) SHALL discard the job, with no done pulse.

Structure
REQ-036 The shared package npu_pkg SHALL hold the state enum type and the AW/width helper functions.
REQ-037 A single sub-module mac_pe SHALL implement one PE (operand and valid-tag registers plus accumulator); the top instantiates N*N of them with generate loops and the skew chains.

Verification
REQ-038 N=2, DW=8, k_len=2, A=I, B=[[1,2],[3,4]], continuous beats -> row0=(1,2), row1=(3,4); first res_valid 3 cycles after the last beat.
REQ-039 Same job with a_valid low for 3 cycles between beats -> identical results, 2 transfers counted.
REQ-040 k_len=0 -> done pulse 1 cycle after start, res_valid never asserted.
REQ-041 SIGNED=1, all operands -128, k_len=KMAX=64 -> every element = 1048576, no wrap.
REQ-042 res_ready held 0 for 5 cycles during OUTPUT -> row0 is held stable, no row is skipped, and done follows the second handshake.
REQ-043 rst asserted in FEED after 1 of 4 beats -> all outputs return to their reset values; the next 2-beat job produces correct results.
